// File: rtl/intrusion_delay_controller.sv
// Intrusion alarm sequencer: synchronized inputs, beam debounce,
// exit/entry/alarm countdowns and registered display/status outputs.
module intrusion_delay_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned EXIT_DELAY      = 1000,
    parameter int unsigned ENTRY_DELAY     = 500,
    parameter int unsigned ALARM_TIMEOUT   = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_beam,
    input  logic        arm_sw,
    input  logic        disarm_sw,
    output logic        alarm_active,
    output logic        system_armed,
    output logic        disarmed_state,
    output logic [1:0]  display_code,
    output logic [15:0] delay_remaining
);

    typedef enum logic [2:0] {
        S_DISARMED,
        S_EXIT,
        S_ARMED,
        S_ENTRY,
        S_ALARM
    } state_t;

    localparam logic [15:0] L_DEB      = 16'(DEBOUNCE_CYCLES);
    localparam logic [15:0] L_EXIT_M1  = 16'(EXIT_DELAY - 1);
    localparam logic [15:0] L_ENTRY_M1 = 16'(ENTRY_DELAY - 1);
    localparam logic [15:0] L_ALARM_M1 = 16'(ALARM_TIMEOUT - 1);

    logic        r_run;
    logic        r_beam_s1, r_beam_s2;
    logic        r_arm_s1, r_arm_s2, r_arm_prev;
    logic        r_dis_s1, r_dis_s2, r_dis_prev;
    logic [15:0] r_deb;
    logic [15:0] r_cnt;
    state_t      r_state;

    logic        w_arm_evt;
    logic        w_dis_evt;
    logic        w_beam_broken;
    logic        w_deb_clr;
    state_t      w_next;
    logic [15:0] w_next_cnt;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beam_s1  <= 1'b0;
            r_beam_s2  <= 1'b0;
            r_arm_s1   <= 1'b0;
            r_arm_s2   <= 1'b0;
            r_arm_prev <= 1'b0;
            r_dis_s1   <= 1'b0;
            r_dis_s2   <= 1'b0;
            r_dis_prev <= 1'b0;
        end else if (!r_run) begin
            r_beam_s1  <= 1'b0;
            r_beam_s2  <= 1'b0;
            r_arm_s1   <= 1'b0;
            r_arm_s2   <= 1'b0;
            r_arm_prev <= 1'b0;
            r_dis_s1   <= 1'b0;
            r_dis_s2   <= 1'b0;
            r_dis_prev <= 1'b0;
        end else begin
            r_beam_s1  <= ir_beam;
            r_beam_s2  <= r_beam_s1;
            r_arm_s1   <= arm_sw;
            r_arm_s2   <= r_arm_s1;
            r_arm_prev <= r_arm_s2;
            r_dis_s1   <= disarm_sw;
            r_dis_s2   <= r_dis_s1;
            r_dis_prev <= r_dis_s2;
        end
    end

    assign w_arm_evt     = r_arm_s2 & ~r_arm_prev;
    assign w_dis_evt     = r_dis_s2 & ~r_dis_prev;
    assign w_beam_broken = (r_deb == L_DEB);
    assign w_deb_clr     = (r_state == S_ALARM) && (w_next == S_ARMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= 16'd0;
        end else if (!r_run || w_deb_clr || r_beam_s2) begin
            r_deb <= 16'd0;
        end else if (r_deb != L_DEB) begin
            r_deb <= r_deb + 16'd1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_next_cnt = r_cnt;
        if (w_dis_evt) begin
            w_next     = S_DISARMED;
            w_next_cnt = 16'd0;
        end else begin
            unique case (r_state)
                S_DISARMED: begin
                    if (w_arm_evt) begin
                        w_next     = S_EXIT;
                        w_next_cnt = L_EXIT_M1;
                    end
                end
                S_EXIT: begin
                    if (r_cnt == 16'd0) begin
                        w_next     = S_ARMED;
                        w_next_cnt = 16'd0;
                    end else begin
                        w_next_cnt = r_cnt - 16'd1;
                    end
                end
                S_ARMED: begin
                    if (w_beam_broken) begin
                        w_next     = S_ENTRY;
                        w_next_cnt = L_ENTRY_M1;
                    end
                end
                S_ENTRY: begin
                    if (r_cnt == 16'd0) begin
                        w_next     = S_ALARM;
                        w_next_cnt = L_ALARM_M1;
                    end else begin
                        w_next_cnt = r_cnt - 16'd1;
                    end
                end
                S_ALARM: begin
                    if (r_cnt == 16'd0) begin
                        w_next     = S_ARMED;
                        w_next_cnt = 16'd0;
                    end else begin
                        w_next_cnt = r_cnt - 16'd1;
                    end
                end
                default: begin
                    w_next     = S_DISARMED;
                    w_next_cnt = 16'd0;
                end
            endcase
        end
    end

    // Outputs decode w_next so they move on the same edge as r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_DISARMED;
            r_cnt          <= 16'd0;
            alarm_active   <= 1'b0;
            system_armed   <= 1'b0;
            disarmed_state <= 1'b1;
            display_code   <= 2'b00;
        end else if (!r_run) begin
            r_state        <= S_DISARMED;
            r_cnt          <= 16'd0;
            alarm_active   <= 1'b0;
            system_armed   <= 1'b0;
            disarmed_state <= 1'b1;
            display_code   <= 2'b00;
        end else begin
            r_state        <= w_next;
            r_cnt          <= w_next_cnt;
            alarm_active   <= (w_next == S_ALARM);
            system_armed   <= (w_next == S_ARMED) ||
                              (w_next == S_ENTRY) ||
                              (w_next == S_ALARM);
            disarmed_state <= (w_next == S_DISARMED);
            unique case (w_next)
                S_EXIT, S_ENTRY: display_code <= 2'b01;
                S_ARMED:         display_code <= 2'b10;
                S_ALARM:         display_code <= 2'b11;
                default:         display_code <= 2'b00;
            endcase
        end
    end

    assign delay_remaining = r_cnt;

endmodule

// File: tb/tb_intrusion_delay_controller.sv
// Directed bench for intrusion_delay_controller with short delays.
module tb_intrusion_delay_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir_beam;
    logic        arm_sw;
    logic        disarm_sw;
    logic        alarm_active;
    logic        system_armed;
    logic        disarmed_state;
    logic [1:0]  display_code;
    logic [15:0] delay_remaining;

    int n_total  = 0;
    int n_passed = 0;

    // {alarm, armed, disarmed, code[1:0], remaining[15:0]}
    localparam logic [20:0] E_DIS = {3'b001, 2'b00, 16'd0};
    localparam logic [20:0] E_ARM = {3'b010, 2'b10, 16'd0};

    intrusion_delay_controller #(
        .DEBOUNCE_CYCLES(4),
        .EXIT_DELAY(8),
        .ENTRY_DELAY(6),
        .ALARM_TIMEOUT(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ir_beam(ir_beam),
        .arm_sw(arm_sw),
        .disarm_sw(disarm_sw),
        .alarm_active(alarm_active),
        .system_armed(system_armed),
        .disarmed_state(disarmed_state),
        .display_code(display_code),
        .delay_remaining(delay_remaining)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] e_exit(int c);
        return {3'b000, 2'b01, 16'(c)};
    endfunction

    function automatic logic [20:0] e_ent(int c);
        return {3'b010, 2'b01, 16'(c)};
    endfunction

    function automatic logic [20:0] e_alm(int c);
        return {3'b110, 2'b11, 16'(c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [20:0] exp);
        logic [20:0] obs;
        obs = {alarm_active, system_armed, disarmed_state,
               display_code, delay_remaining};
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst_n     = 1'b1;
        ir_beam   = 1'b1;
        arm_sw    = 1'b0;
        disarm_sw = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("reset_async", E_DIS);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("idle", E_DIS);

        // Arm: two sync edges, then 8 cycles of exit delay.
        arm_sw = 1'b1;
        tick();
        tick();
        chk("arm_sync_lat", E_DIS);
        tick();
        chk("exit_start", e_exit(7));
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("exit_cnt", e_exit(7 - i));
        end
        tick();
        chk("armed", E_ARM);
        arm_sw = 1'b0;

        ir_beam = 1'b0;
        repeat (3) tick();
        ir_beam = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("short_beam", E_ARM);
        end

        ir_beam = 1'b0;
        repeat (6) tick();
        chk("deb_not_yet", E_ARM);
        tick();
        chk("entry_start", e_ent(5));
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("entry_cnt", e_ent(5 - i));
        end
        tick();
        chk("alarm_on", e_alm(19));
        repeat (10) tick();
        chk("alarm_mid", e_alm(9));
        repeat (9) tick();
        chk("alarm_end", e_alm(0));
        tick();
        chk("rearm", E_ARM);
        repeat (4) tick();
        chk("rearm_need_fresh", E_ARM);
        tick();
        chk("entry_again", e_ent(5));

        // Disarm lands exactly when the countdown shows 1.
        tick();
        tick();
        disarm_sw = 1'b1;
        tick();
        tick();
        chk("dis_lat", e_ent(1));
        tick();
        chk("dis_entry", E_DIS);
        disarm_sw = 1'b0;
        ir_beam   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_alarm", E_DIS);
        end

        arm_sw = 1'b1;
        repeat (3) tick();
        chk("arm2_exit", e_exit(7));
        repeat (8) tick();
        chk("arm2_armed", E_ARM);
        arm_sw = 1'b0;
        repeat (4) tick();
        arm_sw    = 1'b1;
        disarm_sw = 1'b1;
        tick();
        tick();
        chk("both_lat", E_ARM);
        tick();
        chk("both_dis", E_DIS);
        disarm_sw = 1'b0;
        repeat (10) tick();
        chk("arm_held", E_DIS);
        arm_sw = 1'b0;
        repeat (4) tick();
        arm_sw = 1'b1;
        repeat (3) tick();
        chk("rearm_edge", e_exit(7));
        arm_sw = 1'b0;
        repeat (8) tick();
        chk("arm3_armed", E_ARM);

        ir_beam = 1'b0;
        repeat (7) tick();
        chk("entry3", e_ent(5));
        repeat (6) tick();
        chk("alarm3", e_alm(19));
        repeat (3) tick();
        chk("alarm3_cnt", e_alm(16));
        rst_n = 1'b0;
        #1 chk("rst_in_alarm", E_DIS);
        tick();
        chk("rst_held", E_DIS);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_a", E_DIS);
        repeat (15) tick();
        chk("post_rst_b", E_DIS);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
